// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one variable-latency memory port between the instruction-fetch
// requester (IF stage) and the data requester (MEM stage). One memory
// transaction is in flight at a time. Data has priority over fetch. A
// completed result is held, with its ready flag, until the pipeline advances.
// An advance is any cycle in which stall_o is low.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), async active-high reset
//   if_req_i/if_addr_i        fetch request (level) and PC
//   if_data_o/if_ready_o      fetched instruction, held-result flag
//   d_req_i/d_we_i/d_addr_i   data request (level), write select, address
//   d_wdata_i                 store data
//   d_rdata_o/d_ready_o       load data, held-result flag
//   mem_req_o/mem_we_o        registered memory request / write enable
//   mem_addr_o/mem_wdata_o    registered memory address / write data
//   mem_ack_i/mem_rdata_i     1-cycle completion pulse, read data
//   stall_o                   combinational pipeline freeze
//   timeout_o                 sticky abort flag (set when MAX_WAIT expires)
//
// Optional build macro MEM_ARB_PERF_EN adds three saturating 32-bit counters:
//   perf_istall_o  cycles stalled only because of fetch
//   perf_dstall_o  cycles with a pending data request
//   perf_xact_o    transactions completed by mem_ack_i
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic              timeout_o
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_istall_o,
    output logic [31:0]       perf_dstall_o,
    output logic [31:0]       perf_xact_o
`endif
);

    localparam bit TO_EN = (MAX_WAIT > 0);
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    // The abort fires at the edge where the counter would reach MAX_WAIT,
    // so mem_req_o is high for exactly MAX_WAIT cycles.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DBUSY = 2'd1,
        IBUSY = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt_q;

    logic d_pend;
    logic i_pend;
    logic advance;
    logic busy;
    logic ack_hit;
    logic to_hit;
    logic xact_end;
    logic issue_d;
    logic issue_i;
    logic done_d;
    logic done_i;

    // A requester is pending only while it has no held result; this is what
    // keeps a frozen requester from being served twice.
    assign d_pend   = d_req_i & ~d_ready_o;
    assign i_pend   = if_req_i & ~if_ready_o;
    assign advance  = ~(d_pend | i_pend);
    assign busy     = (state_q != IDLE);
    assign ack_hit  = busy & mem_ack_i;
    // Ack takes precedence over an expiring counter.
    assign to_hit   = TO_EN && busy && !mem_ack_i && (wait_cnt_q == WAIT_LAST);
    assign xact_end = ack_hit | to_hit;

    // Gated by reset so the freeze drops immediately, not at the next edge.
    assign stall_o = ~rst_i & (d_pend | i_pend);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_pend) begin
                    state_d = DBUSY;
                end else if (i_pend) begin
                    state_d = IBUSY;
                end
            end
            DBUSY, IBUSY: begin
                if (xact_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: per-cycle strobes for the registered port logic
    always_comb begin
        issue_d = 1'b0;
        issue_i = 1'b0;
        done_d  = 1'b0;
        done_i  = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_pend) begin
                    issue_d = 1'b1;
                end else if (i_pend) begin
                    issue_i = 1'b1;
                end
            end
            DBUSY:   done_d = xact_end;
            IBUSY:   done_i = xact_end;
            default: ;
        endcase
    end

    // Memory port, result holding and sticky abort flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            d_rdata_o   <= '0;
            d_ready_o   <= 1'b0;
            if_data_o   <= '0;
            if_ready_o  <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            if (issue_d) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= d_we_i;
                mem_addr_o  <= d_addr_i;
                mem_wdata_o <= d_wdata_i;
            end else if (issue_i) begin
                mem_req_o  <= 1'b1;
                mem_we_o   <= 1'b0;
                mem_addr_o <= if_addr_i;
            end else if (xact_end) begin
                mem_req_o <= 1'b0;
                mem_we_o  <= 1'b0;
            end

            // Completion has priority over the advance clear so a result
            // finishing in an advance cycle (dropped request) is still
            // presented once.
            if (done_d) begin
                d_ready_o <= 1'b1;
                if (to_hit) begin
                    d_rdata_o <= '0;
                end else if (!mem_we_o) begin
                    d_rdata_o <= mem_rdata_i;
                end
            end else if (advance) begin
                d_ready_o <= 1'b0;
            end

            if (done_i) begin
                if_ready_o <= 1'b1;
                if_data_o  <= to_hit ? '0 : mem_rdata_i;
            end else if (advance) begin
                if_ready_o <= 1'b0;
            end

            if (to_hit) begin
                timeout_o <= 1'b1;
            end
        end
    end

    // Busy-cycle wait counter; restarts whenever the arbiter leaves busy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else if (TO_EN && busy && !xact_end) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_q <= '0;
        end
    end

`ifdef MEM_ARB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_istall_o <= '0;
            perf_dstall_o <= '0;
            perf_xact_o   <= '0;
        end else begin
            if (i_pend && !d_pend) begin
                perf_istall_o <= sat_inc(perf_istall_o);
            end
            if (d_pend) begin
                perf_dstall_o <= sat_inc(perf_dstall_o);
            end
            if (ack_hit) begin
                perf_xact_o <= sat_inc(perf_xact_o);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter (MAX_WAIT = 4). The bench plays the memory:
// it waits for mem_req_o, checks the presented command and returns an ack a
// chosen number of cycles later. Inputs are driven 1 ns after the rising edge
// or on the falling edge; outputs are sampled on the falling edge or 1 ns
// after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic [DW-1:0] if_data_o;
    logic          if_ready_o;
    logic          d_req_i;
    logic          d_we_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic [DW-1:0] d_rdata_o;
    logic          d_ready_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_rdata_i;
    logic          stall_o;
    logic          timeout_o;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   perf_istall_o;
    logic [31:0]   perf_dstall_o;
    logic [31:0]   perf_xact_o;
`endif

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc_no = 0;
    int pulses = 0;
    logic req_prev = 1'b0;

    mem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_data_o   (if_data_o),
        .if_ready_o  (if_ready_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_rdata_o   (d_rdata_o),
        .d_ready_o   (d_ready_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .timeout_o   (timeout_o)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_istall_o (perf_istall_o),
        .perf_dstall_o (perf_dstall_o),
        .perf_xact_o   (perf_xact_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc_no++;

    // Counts rising edges of mem_req_o; a rise implies it was low the cycle before.
    always @(negedge clk_i) begin
        if (mem_req_o && !req_prev) pulses++;
        req_prev = mem_req_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    // Plays one memory transaction: waits (bounded) for the request, checks
    // the command, then acks in the lat-th cycle of the request.
    task automatic serve(input string tag, input logic [31:0] ea, input logic ewe,
                         input logic [31:0] ewd, input logic [31:0] rd, input int lat);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!mem_req_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_req"}, 64'(mem_req_o), 64'(1'b1));
        check({tag, "_addr"}, 64'(mem_addr_o), 64'(ea));
        check({tag, "_we"}, 64'(mem_we_o), 64'(ewe));
        if (ewe) check({tag, "_wdata"}, 64'(mem_wdata_o), 64'(ewd));
        for (int i = 1; i < lat; i++) @(negedge clk_i);
        check({tag, "_hold"}, 64'({mem_req_o, mem_we_o, mem_addr_o}), 64'({1'b1, ewe, ea}));
        mem_ack_i   = 1'b1;
        mem_rdata_i = rd;
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
    endtask

    initial begin
        int t0;
        int n;
        int base;

        rst_i       = 1'b1;
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        d_req_i     = 1'b1;
        d_we_i      = 1'b0;
        d_addr_i    = '0;
        d_wdata_i   = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;

        // Reset state (d_req_i held high: stall must still be 0)
        repeat (2) @(negedge clk_i);
        check("rst_mem_req", 64'(mem_req_o), 64'(0));
        check("rst_stall", 64'(stall_o), 64'(0));
        check("rst_ready", 64'({if_ready_o, d_ready_o}), 64'(0));
        check("rst_data", 64'({if_data_o, d_rdata_o}), 64'(0));
        check("rst_timeout", 64'(timeout_o), 64'(0));
        d_req_i = 1'b0;
        rst_i   = 1'b0;
        nxt();

        // Fetch only, ack in the third request cycle
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0040;
        t0 = cyc_no;
        #1 check("f_stall_on", 64'(stall_o), 64'(1));
        serve("f", 32'h40, 1'b0, 32'h0, 32'h2008_0005, 3);
        check("f_ready", 64'(if_ready_o), 64'(1));
        check("f_data", 64'(if_data_o), 64'(32'h2008_0005));
        check("f_stall_off", 64'(stall_o), 64'(0));
        check("f_stall_cycles", 64'(cyc_no - t0), 64'(4));
        if_req_i = 1'b0;
        nxt();
        check("f_ready_clr", 64'(if_ready_o), 64'(0));

        // Simultaneous data read and fetch: data first
        base = pulses;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_addr_i  = 32'h100;
        if_req_i  = 1'b1;
        if_addr_i = 32'h44;
        serve("sd", 32'h100, 1'b0, 32'h0, 32'h1111_2222, 1);
        check("sd_ready", 64'({d_ready_o, if_ready_o}), 64'(2'b10));
        check("sd_rdata", 64'(d_rdata_o), 64'(32'h1111_2222));
        check("sd_stall", 64'(stall_o), 64'(1));
        serve("si", 32'h44, 1'b0, 32'h0, 32'h3333_4444, 2);
        check("si_ready", 64'({d_ready_o, if_ready_o}), 64'(2'b11));
        check("si_data", 64'(if_data_o), 64'(32'h3333_4444));
        check("si_stall", 64'(stall_o), 64'(0));
        check("si_pulses", 64'(pulses - base), 64'(2));
        d_req_i  = 1'b0;
        if_req_i = 1'b0;
        nxt();
        check("si_ready_clr", 64'({d_ready_o, if_ready_o}), 64'(0));

        // Store: write command presented, load data untouched
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h8;
        d_wdata_i = 32'hDEAD_BEEF;
        serve("st", 32'h8, 1'b1, 32'hDEAD_BEEF, 32'h5555_5555, 2);
        check("st_ready", 64'(d_ready_o), 64'(1));
        check("st_rdata", 64'(d_rdata_o), 64'(32'h1111_2222));
        check("st_we_clr", 64'({mem_req_o, mem_we_o}), 64'(0));
        d_req_i = 1'b0;
        d_we_i  = 1'b0;
        nxt();

        // Timeout: no ack for a data read
        d_req_i  = 1'b1;
        d_addr_i = 32'h200;
        n = 0;
        @(negedge clk_i);
        while (!mem_req_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("to_req", 64'(mem_req_o), 64'(1));
        n = 0;
        while (mem_req_o && n < 20) begin
            n++;
            @(negedge clk_i);
        end
        check("to_busy_cycles", 64'(n), 64'(4));
        check("to_flag", 64'(timeout_o), 64'(1));
        check("to_ready", 64'(d_ready_o), 64'(1));
        check("to_rdata", 64'(d_rdata_o), 64'(0));
        check("to_stall", 64'(stall_o), 64'(0));
        nxt();
        d_req_i   = 1'b0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h80;
        serve("ta", 32'h80, 1'b0, 32'h0, 32'h1357_9BDF, 1);
        check("ta_data", 64'(if_data_o), 64'(32'h1357_9BDF));
        check("ta_sticky", 64'(timeout_o), 64'(1));
        if_req_i = 1'b0;
        nxt();

        // Asynchronous reset in the middle of a data transaction
        d_req_i  = 1'b1;
        d_addr_i = 32'h300;
        n = 0;
        @(negedge clk_i);
        while (!mem_req_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("rm_req_before", 64'(mem_req_o), 64'(1));
        #2 rst_i = 1'b1;
        #1;
        check("rm_req", 64'(mem_req_o), 64'(0));
        check("rm_stall", 64'(stall_o), 64'(0));
        check("rm_ready", 64'({if_ready_o, d_ready_o}), 64'(0));
        check("rm_timeout", 64'(timeout_o), 64'(0));
        check("rm_ifdata", 64'(if_data_o), 64'(0));
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        serve("rr", 32'h300, 1'b0, 32'h0, 32'h2468_ACE0, 1);
        check("rr_rdata", 64'(d_rdata_o), 64'(32'h2468_ACE0));
        d_req_i = 1'b0;
        nxt();

        // Ack in the same cycle the wait counter expires: ack wins
        d_req_i  = 1'b1;
        d_addr_i = 32'h400;
        serve("bw", 32'h400, 1'b0, 32'h0, 32'h0BAD_F00D, 4);
        check("bw_rdata", 64'(d_rdata_o), 64'(32'h0BAD_F00D));
        check("bw_ready", 64'(d_ready_o), 64'(1));
        check("bw_no_timeout", 64'(timeout_o), 64'(0));
        d_req_i = 1'b0;
        nxt();

        // Five back-to-back fetches, ack in the first request cycle
        rst_i = 1'b1;
        #2 rst_i = 1'b0;
        nxt();
        base = pulses;
        for (int k = 0; k < 5; k++) begin
            if_req_i  = 1'b1;
            if_addr_i = 32'h1000 + 32'(4 * k);
            serve("bb", 32'h1000 + 32'(4 * k), 1'b0, 32'h0, 32'hA000_0000 + 32'(k), 1);
            check("bb_data", 64'(if_data_o), 64'(32'hA000_0000 + 32'(k)));
            check("bb_ready", 64'(if_ready_o), 64'(1));
        end
        if_req_i = 1'b0;
        nxt();
        check("bb_pulses", 64'(pulses - base), 64'(5));
`ifdef MEM_ARB_PERF_EN
        check("perf_xact", 64'(perf_xact_o), 64'(5));
        check("perf_istall", 64'(perf_istall_o), 64'(10));
        check("perf_dstall", 64'(perf_dstall_o), 64'(0));
`endif

        // Ack while idle is ignored
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFFFF_FFFF;
        nxt();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        check("idle_ack_ready", 64'({if_ready_o, d_ready_o}), 64'(0));
        check("idle_ack_data", 64'(if_data_o), 64'(32'hA000_0004));
        check("idle_ack_req", 64'(mem_req_o), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
